// File: rtl/moldudp64_pkg.sv
// Shared MoldUDP64 request definitions.
// Request packet layout constants and the request serialiser FSM states.
package moldudp64_pkg;

   localparam int REQ_BYTES   = 20;
   localparam int REQ_SID_OFF = 0;
   localparam int REQ_SEQ_OFF = 10;
   localparam int REQ_CNT_OFF = 18;
   localparam int SEQ_WIRE_W  = 64;

   typedef enum logic [1:0] {
      IDLE,
      B0,
      B1,
      B2
   } req_fsm_e;

endpackage

// File: rtl/miss_req_tx.sv
// MoldUDP64 retransmission request transmitter: gap descriptors in,
// 20-byte requests out as three 64-bit beats (valid/ready, keep, last).
module miss_req_tx
   import moldudp64_pkg::*;
#(
   parameter int SEQ_NUM_W = 18,
   parameter int SID_W     = 80,
   parameter int ML_W      = 16,
   parameter int REQ_MAX   = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 miss_v_i,
   output logic                 miss_rdy_o,
   input  logic [SID_W-1:0]     miss_sid_i,
   input  logic [SEQ_NUM_W-1:0] miss_seq_start_i,
   input  logic [SEQ_NUM_W-1:0] miss_seq_cnt_i,
   output logic                 req_v_o,
   input  logic                 req_rdy_i,
   output logic [63:0]          req_data_o,
   output logic [7:0]           req_keep_o,
   output logic                 req_last_o
);

   localparam int PKT_W = SID_W + SEQ_WIRE_W + ML_W;
   localparam logic [SEQ_NUM_W-1:0] REQ_MAX_S = SEQ_NUM_W'(REQ_MAX);

   req_fsm_e state, state_nx;

   logic [SID_W-1:0]     sid_q;
   logic [SEQ_NUM_W-1:0] start_q;
   logic [SEQ_NUM_W-1:0] rem_q;
   logic [SEQ_NUM_W-1:0] cnt;
   logic [PKT_W-1:0]     pkt;
   logic [63:0]          beat0, beat1, beat2;
   logic                 acc, hs;

   assign miss_rdy_o = (state == IDLE);
   assign req_v_o    = (state != IDLE);
   assign acc        = miss_v_i & miss_rdy_o;
   assign hs         = req_v_o & req_rdy_i;

   assign cnt = (rem_q > REQ_MAX_S) ? REQ_MAX_S : rem_q;

   // Network order: packet byte 0 sits in the top byte of pkt.
   assign pkt = {sid_q, SEQ_WIRE_W'(start_q), ML_W'(cnt)};

   // Beat lane i carries packet byte (beat offset + i).
   always_comb begin
      beat0 = '0;
      beat1 = '0;
      beat2 = '0;
      for (int i = 0; i < 8; i++) begin
         beat0[8*i +: 8] = pkt[PKT_W-1-8*i -: 8];
         beat1[8*i +: 8] = pkt[PKT_W-1-8*(8+i) -: 8];
      end
      for (int i = 0; i < 4; i++) begin
         beat2[8*i +: 8] = pkt[PKT_W-1-8*(16+i) -: 8];
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state   <= IDLE;
         sid_q   <= '0;
         start_q <= '0;
         rem_q   <= '0;
      end else begin
         state <= state_nx;
         if (acc) begin
            sid_q   <= miss_sid_i;
            start_q <= miss_seq_start_i;
            rem_q   <= miss_seq_cnt_i;
         end else if (state == B2 && hs) begin
            start_q <= start_q + cnt;
            rem_q   <= rem_q - cnt;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      req_data_o = '0;
      req_keep_o = '0;
      req_last_o = 1'b0;
      unique case (state)
         IDLE: begin
            if (acc && miss_seq_cnt_i != '0) state_nx = B0;
         end
         B0: begin
            req_data_o = beat0;
            req_keep_o = 8'hFF;
            if (hs) state_nx = B1;
         end
         B1: begin
            req_data_o = beat1;
            req_keep_o = 8'hFF;
            if (hs) state_nx = B2;
         end
         B2: begin
            req_data_o = beat2;
            req_keep_o = 8'h0F;
            req_last_o = 1'b1;
            // cnt never exceeds rem_q, so equality means this was the last chunk
            if (hs) state_nx = (rem_q == cnt) ? IDLE : B0;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_miss_req_tx.sv
// Scoreboard bench for miss_req_tx with REQ_MAX = 4.
// Driver pushes expected beats; a negedge monitor pops and compares.
module tb_miss_req_tx;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   logic        clk = 0;
   logic        nreset = 0;
   logic        miss_v_i = 0;
   logic        miss_rdy_o;
   logic [79:0] miss_sid_i = '0;
   logic [17:0] miss_seq_start_i = '0;
   logic [17:0] miss_seq_cnt_i = '0;
   logic        req_v_o;
   logic        req_rdy_i = 1;
   logic [63:0] req_data_o;
   logic [7:0]  req_keep_o;
   logic        req_last_o;

   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;
   beat_t exp_q[$];

   logic        prev_stall = 0;
   logic [63:0] prev_data;
   logic [7:0]  prev_keep;
   logic        prev_last;

   miss_req_tx #(
      .SEQ_NUM_W (18),
      .SID_W     (80),
      .ML_W      (16),
      .REQ_MAX   (4)
   ) dut (
      .clk              (clk),
      .nreset           (nreset),
      .miss_v_i         (miss_v_i),
      .miss_rdy_o       (miss_rdy_o),
      .miss_sid_i       (miss_sid_i),
      .miss_seq_start_i (miss_seq_start_i),
      .miss_seq_cnt_i   (miss_seq_cnt_i),
      .req_v_o          (req_v_o),
      .req_rdy_i        (req_rdy_i),
      .req_data_o       (req_data_o),
      .req_keep_o       (req_keep_o),
      .req_last_o       (req_last_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_beat(input logic [63:0] d, input logic [7:0] k,
                            input logic l);
      beat_t b;
      b.data = d;
      b.keep = k;
      b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic push_pkt(input logic [79:0] sid, input logic [17:0] seq,
                           input logic [15:0] cnt);
      logic [7:0]  by [20];
      logic [63:0] seq64;
      logic [63:0] d0, d1, d2;
      seq64 = {46'd0, seq};
      for (int i = 0; i < 10; i++) by[i] = sid[79-8*i -: 8];
      for (int i = 0; i < 8; i++) by[10+i] = seq64[63-8*i -: 8];
      by[18] = cnt[15:8];
      by[19] = cnt[7:0];
      d0 = '0;
      d1 = '0;
      d2 = '0;
      for (int i = 0; i < 8; i++) begin
         d0[8*i +: 8] = by[i];
         d1[8*i +: 8] = by[8+i];
      end
      for (int i = 0; i < 4; i++) d2[8*i +: 8] = by[16+i];
      push_beat(d0, 8'hFF, 1'b0);
      push_beat(d1, 8'hFF, 1'b0);
      push_beat(d2, 8'h0F, 1'b1);
   endtask

   // ready generator: 0 = always high, 1 = random, 2 = driven by the test
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) req_rdy_i = 1'b1;
      else if (rdy_mode == 1) req_rdy_i = 1'($urandom_range(0, 1));
   end

   // monitor
   always @(negedge clk) begin
      beat_t e;
      if (!nreset) begin
         prev_stall = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 64'(req_v_o), 64'd1);
            chk("stall_data", req_data_o, prev_data);
            chk("stall_keep", 64'(req_keep_o), 64'(prev_keep));
            chk("stall_last", 64'(req_last_o), 64'(prev_last));
         end
         if (req_v_o) begin
            chk("rdy_low_busy", 64'(miss_rdy_o), 64'd0);
            if (req_rdy_i) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %h expected none",
                           req_data_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_data", req_data_o, e.data);
                  chk("beat_keep", 64'(req_keep_o), 64'(e.keep));
                  chk("beat_last", 64'(req_last_o), 64'(e.last));
               end
            end
         end else begin
            chk("idle_data", req_data_o, 64'd0);
            chk("idle_keep", 64'(req_keep_o), 64'd0);
            chk("idle_last", 64'(req_last_o), 64'd0);
         end
         prev_stall = req_v_o & ~req_rdy_i;
         prev_data  = req_data_o;
         prev_keep  = req_keep_o;
         prev_last  = req_last_o;
      end
   end

   // exp_cycles: >=0 check drain length, -1 drain without length check,
   // -2 return right after acceptance
   task automatic send(input logic [79:0] sid, input logic [17:0] st,
                       input logic [17:0] c, input int exp_cycles);
      int n;
      bit ok;
      @(posedge clk);
      #1;
      miss_v_i         = 1;
      miss_sid_i       = sid;
      miss_seq_start_i = st;
      miss_seq_cnt_i   = c;
      n  = 0;
      ok = 0;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (miss_rdy_o) ok = 1;
         n++;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got miss_rdy_o 0 expected 1");
      end
      @(posedge clk);
      #1;
      miss_v_i = 0;
      if (c != 0) begin
         @(negedge clk);
         chk("latency_v", 64'(req_v_o), 64'd1);
      end
      if (exp_cycles != -2) begin
         n = 0;
         while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
         end
         if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
         end
         if (exp_cycles >= 0) chk("drain_cycles", 64'(n), 64'(exp_cycles));
         @(negedge clk);
         chk("rdy_after", 64'(miss_rdy_o), 64'd1);
      end
   endtask

   localparam logic [79:0] SID_A = 80'h0102030405060708090A;
   localparam logic [79:0] SID_B = 80'hA1B2C3D4E5F60718293A;

   initial begin
      #3;
      chk("rst_rdy", 64'(miss_rdy_o), 64'd1);
      chk("rst_v", 64'(req_v_o), 64'd0);
      chk("rst_data", req_data_o, 64'd0);
      chk("rst_keep", 64'(req_keep_o), 64'd0);
      chk("rst_last", 64'(req_last_o), 64'd0);
      #20;
      nreset = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_rdy", 64'(miss_rdy_o), 64'd1);

      // basic packet, hand-written beats
      push_beat(64'h0807060504030201, 8'hFF, 1'b0);
      push_beat(64'h0000000000000A09, 8'hFF, 1'b0);
      push_beat(64'h0000000003000500, 8'h0F, 1'b1);
      send(SID_A, 18'd5, 18'd3, 3);

      // split into REQ_MAX chunks, back-to-back
      push_pkt(SID_B, 18'd10, 16'd4);
      push_pkt(SID_B, 18'd14, 16'd4);
      push_pkt(SID_B, 18'd18, 16'd1);
      send(SID_B, 18'd10, 18'd9, 9);

      // exactly REQ_MAX: one packet
      push_pkt(SID_A, 18'd100, 16'd4);
      send(SID_A, 18'd100, 18'd4, 3);

      // sequence wraps between chunks
      push_pkt(SID_B, 18'h3FFFE, 16'd4);
      push_pkt(SID_B, 18'd2, 16'd2);
      send(SID_B, 18'h3FFFE, 18'd6, 6);

      // random backpressure, same content as no-backpressure cases
      rdy_mode = 1;
      push_beat(64'h0807060504030201, 8'hFF, 1'b0);
      push_beat(64'h0000000000000A09, 8'hFF, 1'b0);
      push_beat(64'h0000000003000500, 8'h0F, 1'b1);
      send(SID_A, 18'd5, 18'd3, -1);
      push_pkt(SID_B, 18'd10, 16'd4);
      push_pkt(SID_B, 18'd14, 16'd4);
      push_pkt(SID_B, 18'd18, 16'd1);
      send(SID_B, 18'd10, 18'd9, -1);
      rdy_mode = 0;

      // zero-count descriptor is dropped
      send(SID_A, 18'd7, 18'd0, -2);
      repeat (5) begin
         @(negedge clk);
         chk("zero_v", 64'(req_v_o), 64'd0);
         chk("zero_rdy", 64'(miss_rdy_o), 64'd1);
      end

      // reset while B1 is stalled
      rdy_mode = 2;
      @(posedge clk);
      #1;
      req_rdy_i = 0;
      push_pkt(SID_A, 18'd50, 16'd3);
      send(SID_A, 18'd50, 18'd3, -2);
      @(posedge clk);
      #1;
      req_rdy_i = 1;
      @(posedge clk);
      #1;
      req_rdy_i = 0;
      @(negedge clk);
      chk("b1_keep", 64'(req_keep_o), 64'hFF);
      chk("b1_data", req_data_o, 64'h0000000000000A09);
      #2;
      nreset = 0;
      #1;
      chk("rst_mid_v", 64'(req_v_o), 64'd0);
      chk("rst_mid_data", req_data_o, 64'd0);
      chk("rst_mid_keep", 64'(req_keep_o), 64'd0);
      chk("rst_mid_last", 64'(req_last_o), 64'd0);
      chk("rst_mid_rdy", 64'(miss_rdy_o), 64'd1);
      exp_q.delete();
      @(negedge clk);
      #2;
      nreset = 1;
      rdy_mode = 0;
      push_pkt(SID_B, 18'd77, 16'd2);
      send(SID_B, 18'd77, 18'd2, 3);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
